// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module : arith_pkg
// Brief  : Shared constants and state encoding for the arithmetic-op sequencer.
// Rev    : 1.0
// ============================================================================
package arith_pkg;

  localparam int W = 3;

  localparam logic [1:0] OP_DEC = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  localparam logic [2:0] SAT_POS = 3'b011;
  localparam logic [2:0] SAT_NEG = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/arith_flag_unit.sv
`default_nettype none
// ============================================================================
// Module : arith_flag_unit
// Brief  : Combinational result/flag derivation with optional saturation.
// Rev    : 1.0
// ============================================================================
module arith_flag_unit
  import arith_pkg::*;
#(
  parameter int W        = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] g,
  input  logic         carry,
  input  logic         load,
  output logic [W-1:0] value,
  output logic         carry_out,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  logic         w_ovf;
  logic [W-1:0] w_sat;

  // Overflow and clamp target per operation; the clamp is only used when w_ovf is set
  always_comb begin
    w_ovf = 1'b0;
    w_sat = g;
    case (op)
      OP_DEC: begin
        w_ovf = (a == SAT_NEG);
        w_sat = SAT_NEG;
      end
      OP_ADD: begin
        w_ovf = (a[W-1] == b[W-1]) && (g[W-1] != a[W-1]);
        w_sat = a[W-1] ? SAT_NEG : SAT_POS;
      end
      OP_SUB: begin
        w_ovf = (a[W-1] != b[W-1]) && (g[W-1] != a[W-1]);
        w_sat = a[W-1] ? SAT_NEG : SAT_POS;
      end
      default: begin
        w_ovf = (b == SAT_NEG);
        w_sat = SAT_POS;
      end
    endcase
  end

  always_comb begin
    value     = g;
    ovf       = w_ovf;
    carry_out = carry;
    if (load) begin
      value     = b;
      ovf       = 1'b0;
      carry_out = 1'b0;
    end else if (SATURATE && w_ovf) begin
      value = w_sat;
    end
  end

  assign zero = (value == '0);
  assign neg  = value[W-1];

endmodule
`default_nettype wire

// File: rtl/arith_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : arith_op_sequencer
// Brief  : Command sequencer around the 3-bit arithmetic unit with accumulator.
// Rev    : 1.0
// ============================================================================
module arith_op_sequencer
  import arith_pkg::*;
#(
  parameter int         W        = 3,
  parameter logic [W-1:0] ACC_RST = '0,
  parameter bit         SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_load,
  input  logic [W-1:0] cmd_operand,
  output logic [W-1:0] au_a,
  output logic [W-1:0] au_b,
  output logic         au_s1,
  output logic         au_s0,
  input  logic [W-1:0] au_g,
  input  logic         au_carry,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_value,
  output logic         res_carry,
  output logic         res_ovf,
  output logic         res_zero,
  output logic         res_neg,
  output logic [7:0]   ops_done
);

  state_t       r_state, w_next;
  logic [W-1:0] r_acc, r_au_a, r_operand;
  logic [1:0]   r_op;
  logic         r_load;
  logic [W-1:0] r_res_value;
  logic         r_res_carry, r_res_ovf, r_res_zero, r_res_neg;
  logic [7:0]   r_ops_done;

  logic [W-1:0] w_value;
  logic         w_carry, w_ovf, w_zero, w_neg;
  logic         w_accept, w_take;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_take   = (r_state == ST_RESP) && res_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP:  if (res_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  arith_flag_unit #(
    .W        (W),
    .SATURATE (SATURATE)
  ) u_flag (
    .op        (r_op),
    .a         (r_au_a),
    .b         (r_operand),
    .g         (au_g),
    .carry     (au_carry),
    .load      (r_load),
    .value     (w_value),
    .carry_out (w_carry),
    .ovf       (w_ovf),
    .zero      (w_zero),
    .neg       (w_neg)
  );

  // au_a is a snapshot of acc taken at accept, so the unit inputs stay frozen
  // even though acc itself updates at the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= ACC_RST;
      r_au_a      <= ACC_RST;
      r_operand   <= '0;
      r_op        <= 2'b00;
      r_load      <= 1'b0;
      r_res_value <= '0;
      r_res_carry <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_neg   <= 1'b0;
      r_ops_done  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= cmd_op;
        r_operand <= cmd_operand;
        r_load    <= cmd_load;
        r_au_a    <= r_acc;
      end
      if (r_state == ST_ISSUE) begin
        r_acc       <= w_value;
        r_res_value <= w_value;
        r_res_carry <= w_carry;
        r_res_ovf   <= w_ovf;
        r_res_zero  <= w_zero;
        r_res_neg   <= w_neg;
      end
      if (w_take) r_ops_done <= r_ops_done + 8'd1;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign res_valid = (r_state == ST_RESP);
  assign au_a      = r_au_a;
  assign au_b      = r_operand;
  assign au_s1     = r_op[1];
  assign au_s0     = r_op[0];
  assign res_value = r_res_value;
  assign res_carry = r_res_carry;
  assign res_ovf   = r_res_ovf;
  assign res_zero  = r_res_zero;
  assign res_neg   = r_res_neg;
  assign ops_done  = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_arith_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_arith_op_sequencer
// Brief  : Directed bench; wrap and saturate variants run side by side.
// Rev    : 1.0
// ============================================================================
module tb_arith_op_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_load, res_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_operand;

  logic       cmd_ready [2];
  logic [2:0] au_a [2];
  logic [2:0] au_b [2];
  logic       au_s1 [2];
  logic       au_s0 [2];
  logic [2:0] au_g [2];
  logic       au_carry [2];
  logic       res_valid [2];
  logic [2:0] res_value [2];
  logic       res_carry [2];
  logic       res_ovf [2];
  logic       res_zero [2];
  logic       res_neg [2];
  logic [7:0] ops_done [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Three-bit arithmetic unit: selects pick the B-side term, carry-in is 1 for SUB/NEG
  function automatic logic [3:0] au_model(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
    case (s)
      2'b00:   return {1'b0, a} + 4'b0111;
      2'b01:   return {1'b0, a} + {1'b0, b};
      2'b10:   return {1'b0, a} + {1'b0, ~b} + 4'd1;
      default: return {1'b0, ~b} + 4'd1;
    endcase
  endfunction

  assign {au_carry[0], au_g[0]} = au_model({au_s1[0], au_s0[0]}, au_a[0], au_b[0]);
  assign {au_carry[1], au_g[1]} = au_model({au_s1[1], au_s0[1]}, au_a[1], au_b[1]);

  arith_op_sequencer #(.W(3), .ACC_RST(3'b000), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_load(cmd_load), .cmd_operand(cmd_operand),
    .au_a(au_a[0]), .au_b(au_b[0]), .au_s1(au_s1[0]), .au_s0(au_s0[0]),
    .au_g(au_g[0]), .au_carry(au_carry[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready), .res_value(res_value[0]), .res_carry(res_carry[0]),
    .res_ovf(res_ovf[0]), .res_zero(res_zero[0]), .res_neg(res_neg[0]),
    .ops_done(ops_done[0])
  );

  arith_op_sequencer #(.W(3), .ACC_RST(3'b000), .SATURATE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_load(cmd_load), .cmd_operand(cmd_operand),
    .au_a(au_a[1]), .au_b(au_b[1]), .au_s1(au_s1[1]), .au_s0(au_s0[1]),
    .au_g(au_g[1]), .au_carry(au_carry[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready), .res_value(res_value[1]), .res_carry(res_carry[1]),
    .res_ovf(res_ovf[1]), .res_zero(res_zero[1]), .res_neg(res_neg[1]),
    .ops_done(ops_done[1])
  );

  typedef struct {
    logic       ld;
    logic [1:0] op;
    logic [2:0] b;
    logic [2:0] v0;   // expected value, wrapping instance
    logic [2:0] v1;   // expected value, saturating instance
    logic       c;
    logic       o;
  } vec_t;

  vec_t       vecs [16];
  logic [2:0] exp_acc [2];
  logic [7:0] exp_ops;

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[sat=%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic do_cmd(input vec_t v);
    logic [2:0] ev;
    cmd_valid   = 1'b1;
    cmd_load    = v.ld;
    cmd_op      = v.op;
    cmd_operand = v.b;
    for (int k = 0; k < 2; k++) chk("cmd_ready_idle", k, 8'(cmd_ready[k]), 8'd1);
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_operand = ~v.b;
    for (int k = 0; k < 2; k++) begin
      chk("res_valid_issue", k, 8'(res_valid[k]), 8'd0);
      chk("au_a_acc", k, 8'(au_a[k]), 8'(exp_acc[k]));
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      ev = (k == 0) ? v.v0 : v.v1;
      chk("res_valid_resp", k, 8'(res_valid[k]), 8'd1);
      chk("res_value", k, 8'(res_value[k]), 8'(ev));
      chk("res_carry", k, 8'(res_carry[k]), 8'(v.c));
      chk("res_ovf", k, 8'(res_ovf[k]), 8'(v.o));
      chk("res_zero", k, 8'(res_zero[k]), 8'(ev == 3'b000));
      chk("res_neg", k, 8'(res_neg[k]), 8'(ev[2]));
      exp_acc[k] = ev;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_ops   = exp_ops + 8'd1;
    for (int k = 0; k < 2; k++) begin
      chk("ops_done", k, ops_done[k], exp_ops);
      chk("cmd_ready_back", k, 8'(cmd_ready[k]), 8'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ld  op     b       v0      v1      c     o
    vecs[0]  = '{1'b1, 2'b11, 3'b101, 3'b101, 3'b101, 1'b0, 1'b0};  // LOAD, op ignored
    vecs[1]  = '{1'b0, 2'b01, 3'b001, 3'b110, 3'b110, 1'b0, 1'b0};  // 101+001
    vecs[2]  = '{1'b1, 2'b01, 3'b011, 3'b011, 3'b011, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 3'b001, 3'b100, 3'b011, 1'b0, 1'b1};  // 3+1 overflows
    vecs[4]  = '{1'b1, 2'b00, 3'b100, 3'b100, 3'b100, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 3'b000, 3'b011, 3'b100, 1'b1, 1'b1};  // DEC of -4
    vecs[6]  = '{1'b0, 2'b11, 3'b100, 3'b100, 3'b011, 1'b0, 1'b1};  // NEG -4
    vecs[7]  = '{1'b1, 2'b00, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 3'b001, 3'b000, 3'b000, 1'b1, 1'b0};  // 1-1
    vecs[9]  = '{1'b0, 2'b10, 3'b010, 3'b110, 3'b110, 1'b0, 1'b0};  // 0-2
    vecs[10] = '{1'b0, 2'b01, 3'b110, 3'b100, 3'b100, 1'b1, 1'b0};  // -2+-2
    vecs[11] = '{1'b0, 2'b10, 3'b011, 3'b001, 3'b100, 1'b1, 1'b1};  // -4-3
    vecs[12] = '{1'b0, 2'b11, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0};  // NEG 0
    vecs[13] = '{1'b0, 2'b00, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0};  // DEC 0
    vecs[14] = '{1'b0, 2'b11, 3'b011, 3'b101, 3'b101, 1'b0, 1'b0};  // NEG 3
    vecs[15] = '{1'b0, 2'b01, 3'b011, 3'b000, 3'b000, 1'b1, 1'b0};  // -3+3

    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00;
    cmd_operand = 3'b000; res_ready = 1'b0;
    exp_acc[0] = 3'b000; exp_acc[1] = 3'b000; exp_ops = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_res_valid", k, 8'(res_valid[k]), 8'd0);
      chk("rst_cmd_ready", k, 8'(cmd_ready[k]), 8'd1);
      chk("rst_ops_done", k, ops_done[k], 8'd0);
      chk("rst_res_value", k, 8'(res_value[k]), 8'd0);
      chk("rst_au_a", k, 8'(au_a[k]), 8'd0);
    end

    foreach (vecs[i]) do_cmd(vecs[i]);

    // Backpressure: result held for 5 cycles while another command is offered
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b01; cmd_operand = 3'b001;
    @(posedge clk); #1;
    cmd_load = 1'b1; cmd_operand = 3'b111;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 2; k++) begin
        chk("hold_res_valid", k, 8'(res_valid[k]), 8'd1);
        chk("hold_res_value", k, 8'(res_value[k]), 8'd1);
        chk("hold_res_carry", k, 8'(res_carry[k]), 8'd0);
        chk("hold_cmd_ready", k, 8'(cmd_ready[k]), 8'd0);
        chk("hold_ops_done", k, ops_done[k], exp_ops);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_ops   = exp_ops + 8'd1;
    exp_acc[0] = 3'b001; exp_acc[1] = 3'b001;
    for (int k = 0; k < 2; k++) chk("hold_ops_after", k, ops_done[k], exp_ops);
    do_cmd('{1'b0, 2'b00, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});  // 1-1, offered LOAD was not taken

    // Reset while a LOAD is in ISSUE drops it entirely
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_op = 2'b00; cmd_operand = 3'b110;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_res_valid", k, 8'(res_valid[k]), 8'd0);
      chk("midrst_cmd_ready", k, 8'(cmd_ready[k]), 8'd1);
      chk("midrst_ops_done", k, ops_done[k], 8'd0);
      chk("midrst_au_a", k, 8'(au_a[k]), 8'd0);
    end
    exp_ops = 8'd0; exp_acc[0] = 3'b000; exp_acc[1] = 3'b000;
    do_cmd('{1'b0, 2'b00, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0});  // DEC of reset acc

    // ops_done wrap: 255 more handshakes takes it from 1 through FF to 00
    for (int i = 0; i < 255; i++) do_cmd('{1'b0, 2'b11, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0});
    for (int k = 0; k < 2; k++) chk("wrap_ops_done", k, ops_done[k], 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
